// File: rtl/pre_mem_stage_pkg.sv
// Shared widths, payload layouts and load/store type bit positions for pre_mem_stage.
package pre_mem_stage_pkg;

  localparam int unsigned ES_TO_PMS_BUS_WD   = 233;
  localparam int unsigned PMS_TO_MS_BUS_WD   = 227;
  localparam int unsigned PMS_FORWARD_BUS_WD = 79;

  typedef enum int unsigned {
    LT_LWR = 0, LT_LWL = 1, LT_LW = 2, LT_LHU = 3, LT_LH = 4, LT_LBU = 5, LT_LB = 6
  } load_bit_e;

  typedef enum int unsigned {
    ST_SWR = 0, ST_SWL = 1, ST_SW = 2, ST_SH = 3, ST_SB = 4
  } store_bit_e;

  typedef struct packed {
    logic [6:0]  load_type;
    logic [4:0]  store_type;
    logic        res_from_mem;
    logic        mem_we;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] rt_value;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_inst_t;

  typedef struct packed {
    logic        inst2_valid;
    es_inst_t    inst2;
    es_inst_t    inst1;
  } es_bus_t;

  typedef struct packed {
    logic [6:0]  load_type;
    logic [1:0]  offset;
    logic        res_from_mem;
    logic        mem_we;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] rt_value;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } ms_inst_t;

  typedef struct packed {
    logic        inst2_valid;
    ms_inst_t    inst2;
    ms_inst_t    inst1;
  } ms_bus_t;

  typedef struct packed {
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
  } fwd_inst_t;

endpackage

// File: rtl/pre_mem_stage_store_align.sv
// Byte strobes and lane-shifted write data for one store slot.
module pre_mem_stage_store_align
  import pre_mem_stage_pkg::*;
(
  input  logic [4:0]  store_type_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] rt_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o
);

  logic [4:0] swl_sh;
  logic [4:0] swr_sh;

  // swl keeps the high bytes of rt in the low lanes; swr moves the low bytes up
  assign swl_sh = {~off_i, 3'b000};
  assign swr_sh = {off_i, 3'b000};

  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = rt_i;
    if (store_type_i[ST_SB]) begin
      wstrb_o = 4'b0001 << off_i;
      wdata_o = {4{rt_i[7:0]}};
    end else if (store_type_i[ST_SH]) begin
      wstrb_o = off_i[1] ? 4'b1100 : 4'b0011;
      wdata_o = {2{rt_i[15:0]}};
    end else if (store_type_i[ST_SW]) begin
      wstrb_o = 4'b1111;
      wdata_o = rt_i;
    end else if (store_type_i[ST_SWL]) begin
      wstrb_o = 4'b1111 >> (~off_i);
      wdata_o = rt_i >> swl_sh;
    end else if (store_type_i[ST_SWR]) begin
      wstrb_o = 4'b1111 << off_i;
      wdata_o = rt_i << swr_sh;
    end
  end

endmodule

// File: rtl/pre_mem_stage.sv
// Dual-issue pre-memory stage: issues data-cache requests and holds the bundle until all are accepted.
module pre_mem_stage
  import pre_mem_stage_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          es_to_pms_valid,
  input  logic [ES_TO_PMS_BUS_WD-1:0]   es_to_pms_bus,
  output logic                          pms_allowin,
  input  logic                          ms_allowin,
  output logic                          pms_to_ms_valid,
  output logic [PMS_TO_MS_BUS_WD-1:0]   pms_to_ms_bus,
  output logic [PMS_FORWARD_BUS_WD-1:0] pms_forward_bus,
  output logic                          data_cache_valid_01,
  output logic                          data_cache_op_01,
  output logic [31:0]                   data_cache_addr_01,
  output logic [3:0]                    data_cache_wstrb_01,
  output logic [31:0]                   data_cache_wdata_01,
  input  logic                          data_cache_addr_ok_01,
  output logic                          data_cache_valid_02,
  output logic                          data_cache_op_02,
  output logic [31:0]                   data_cache_addr_02,
  output logic [3:0]                    data_cache_wstrb_02,
  output logic [31:0]                   data_cache_wdata_02,
  input  logic                          data_cache_addr_ok_02
);

  es_bus_t   es_bus;
  es_bus_t   bus_q, bus_d;
  logic      pms_valid_q, pms_valid_d;
  logic      req_done_01_q, req_done_01_d;
  logic      req_done_02_q, req_done_02_d;
  logic      mem_op_1, mem_op_2;
  logic      inst_ok_1, inst_ok_2;
  logic      pms_ready_go;
  logic      latch_bundle;
  ms_bus_t   ms_bus;
  fwd_inst_t fwd_1, fwd_2;

  assign es_bus = es_to_pms_bus;

  assign mem_op_1 = bus_q.inst1.res_from_mem | bus_q.inst1.mem_we;
  assign mem_op_2 = bus_q.inst2_valid & (bus_q.inst2.res_from_mem | bus_q.inst2.mem_we);

  assign data_cache_valid_01 = pms_valid_q & mem_op_1 & ~req_done_01_q;
  assign data_cache_valid_02 = pms_valid_q & mem_op_2 & ~req_done_02_q;

  assign inst_ok_1    = ~mem_op_1 | data_cache_addr_ok_01 | req_done_01_q;
  assign inst_ok_2    = ~mem_op_2 | data_cache_addr_ok_02 | req_done_02_q;
  assign pms_ready_go = inst_ok_1 & inst_ok_2;

  assign pms_allowin     = ~pms_valid_q | (pms_ready_go & ms_allowin);
  assign pms_to_ms_valid = pms_valid_q & pms_ready_go;
  assign latch_bundle    = es_to_pms_valid & pms_allowin;

  // Next state; a newly latched bundle clears the done flags over any same-cycle accept
  always_comb begin
    pms_valid_d   = pms_valid_q;
    bus_d         = bus_q;
    req_done_01_d = req_done_01_q;
    req_done_02_d = req_done_02_q;
    if (pms_allowin) begin
      pms_valid_d = es_to_pms_valid;
    end
    if (latch_bundle) begin
      bus_d         = es_bus;
      req_done_01_d = 1'b0;
      req_done_02_d = 1'b0;
    end else begin
      if (data_cache_valid_01 & data_cache_addr_ok_01) req_done_01_d = 1'b1;
      if (data_cache_valid_02 & data_cache_addr_ok_02) req_done_02_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pms_valid_q   <= 1'b0;
      bus_q         <= '0;
      req_done_01_q <= 1'b0;
      req_done_02_q <= 1'b0;
    end else begin
      pms_valid_q   <= pms_valid_d;
      bus_q         <= bus_d;
      req_done_01_q <= req_done_01_d;
      req_done_02_q <= req_done_02_d;
    end
  end

  assign data_cache_op_01   = bus_q.inst1.mem_we;
  assign data_cache_addr_01 = {bus_q.inst1.alu_result[31:2], 2'b00};
  assign data_cache_op_02   = bus_q.inst2.mem_we;
  assign data_cache_addr_02 = {bus_q.inst2.alu_result[31:2], 2'b00};

  pre_mem_stage_store_align u_align_01 (
    .store_type_i (bus_q.inst1.store_type),
    .off_i        (bus_q.inst1.alu_result[1:0]),
    .rt_i         (bus_q.inst1.rt_value),
    .wstrb_o      (data_cache_wstrb_01),
    .wdata_o      (data_cache_wdata_01)
  );

  pre_mem_stage_store_align u_align_02 (
    .store_type_i (bus_q.inst2.store_type),
    .off_i        (bus_q.inst2.alu_result[1:0]),
    .rt_i         (bus_q.inst2.rt_value),
    .wstrb_o      (data_cache_wstrb_02),
    .wdata_o      (data_cache_wdata_02)
  );

  // Outgoing bundle: store_type is consumed here, offset is added for load extraction
  always_comb begin
    ms_bus                    = '0;
    ms_bus.inst2_valid        = bus_q.inst2_valid;
    ms_bus.inst1.load_type    = bus_q.inst1.load_type;
    ms_bus.inst1.offset       = bus_q.inst1.alu_result[1:0];
    ms_bus.inst1.res_from_mem = bus_q.inst1.res_from_mem;
    ms_bus.inst1.mem_we       = bus_q.inst1.mem_we;
    ms_bus.inst1.gr_we        = bus_q.inst1.gr_we;
    ms_bus.inst1.dest         = bus_q.inst1.dest;
    ms_bus.inst1.rt_value     = bus_q.inst1.rt_value;
    ms_bus.inst1.alu_result   = bus_q.inst1.alu_result;
    ms_bus.inst1.pc           = bus_q.inst1.pc;
    ms_bus.inst2.load_type    = bus_q.inst2.load_type;
    ms_bus.inst2.offset       = bus_q.inst2.alu_result[1:0];
    ms_bus.inst2.res_from_mem = bus_q.inst2.res_from_mem;
    ms_bus.inst2.mem_we       = bus_q.inst2.mem_we;
    ms_bus.inst2.gr_we        = bus_q.inst2.gr_we;
    ms_bus.inst2.dest         = bus_q.inst2.dest;
    ms_bus.inst2.rt_value     = bus_q.inst2.rt_value;
    ms_bus.inst2.alu_result   = bus_q.inst2.alu_result;
    ms_bus.inst2.pc           = bus_q.inst2.pc;
  end

  assign pms_to_ms_bus = ms_bus;

  always_comb begin
    fwd_1 = '{res_from_mem: bus_q.inst1.res_from_mem, gr_we: bus_q.inst1.gr_we,
              dest: bus_q.inst1.dest, alu_result: bus_q.inst1.alu_result};
    fwd_2 = '0;
    if (bus_q.inst2_valid) begin
      fwd_2 = '{res_from_mem: bus_q.inst2.res_from_mem, gr_we: bus_q.inst2.gr_we,
                dest: bus_q.inst2.dest, alu_result: bus_q.inst2.alu_result};
    end
  end

  assign pms_forward_bus = {pms_valid_q, fwd_1, fwd_2};

endmodule

// File: tb/tb_pre_mem_stage.sv
// Scoreboard bench for pre_mem_stage: directed bundles, expected requests/handoffs queued at issue.
module tb_pre_mem_stage;

  typedef struct packed {
    logic [31:0] addr;
    logic        op;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         es_to_pms_valid;
  logic [232:0] es_to_pms_bus;
  logic         pms_allowin;
  logic         ms_allowin;
  logic         pms_to_ms_valid;
  logic [226:0] pms_to_ms_bus;
  logic [78:0]  pms_forward_bus;
  logic         dc_valid_01, dc_op_01, dc_ok_01;
  logic [31:0]  dc_addr_01, dc_wdata_01;
  logic [3:0]   dc_wstrb_01;
  logic         dc_valid_02, dc_op_02, dc_ok_02;
  logic [31:0]  dc_addr_02, dc_wdata_02;
  logic [3:0]   dc_wstrb_02;

  int pass_cnt = 0;
  int total_cnt = 0;

  req_t         req01_q[$];
  req_t         req02_q[$];
  logic [226:0] ms_q[$];

  pre_mem_stage dut (
    .clk                   (clk),
    .reset                 (reset),
    .es_to_pms_valid       (es_to_pms_valid),
    .es_to_pms_bus         (es_to_pms_bus),
    .pms_allowin           (pms_allowin),
    .ms_allowin            (ms_allowin),
    .pms_to_ms_valid       (pms_to_ms_valid),
    .pms_to_ms_bus         (pms_to_ms_bus),
    .pms_forward_bus       (pms_forward_bus),
    .data_cache_valid_01   (dc_valid_01),
    .data_cache_op_01      (dc_op_01),
    .data_cache_addr_01    (dc_addr_01),
    .data_cache_wstrb_01   (dc_wstrb_01),
    .data_cache_wdata_01   (dc_wdata_01),
    .data_cache_addr_ok_01 (dc_ok_01),
    .data_cache_valid_02   (dc_valid_02),
    .data_cache_op_02      (dc_op_02),
    .data_cache_addr_02    (dc_addr_02),
    .data_cache_wstrb_02   (dc_wstrb_02),
    .data_cache_wdata_02   (dc_wdata_02),
    .data_cache_addr_ok_02 (dc_ok_02)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [115:0] mk_in(input logic [6:0] lt, input logic [4:0] st,
      input logic rfm, input logic mwe, input logic grwe, input logic [4:0] dest,
      input logic [31:0] rt, input logic [31:0] alu, input logic [31:0] pc);
    return {lt, st, rfm, mwe, grwe, dest, rt, alu, pc};
  endfunction

  function automatic logic [112:0] mk_out(input logic [6:0] lt,
      input logic rfm, input logic mwe, input logic grwe, input logic [4:0] dest,
      input logic [31:0] rt, input logic [31:0] alu, input logic [31:0] pc);
    return {lt, alu[1:0], rfm, mwe, grwe, dest, rt, alu, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a bundle and hold it until the stage takes it (bounded)
  task automatic send(input logic [232:0] b);
    bit taken = 0;
    es_to_pms_valid = 1'b1;
    es_to_pms_bus   = b;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pms_allowin) begin
        taken = 1;
        break;
      end
    end
    check("send_accepted", 256'(taken), 256'(1));
    @(posedge clk);
    #1;
    es_to_pms_valid = 1'b0;
  endtask

  // Monitor: compare any presented request/handoff against the queue head, pop on handshake
  always @(negedge clk) begin
    if (!reset) begin
      if (dc_valid_01) begin
        check("req01_expected", 256'(req01_q.size() != 0), 256'(1));
        if (req01_q.size() != 0) begin
          check("req01_addr", 256'(dc_addr_01), 256'(req01_q[0].addr));
          check("req01_op", 256'(dc_op_01), 256'(req01_q[0].op));
          check("req01_wstrb", 256'(dc_wstrb_01), 256'(req01_q[0].wstrb));
          if (req01_q[0].op) check("req01_wdata", 256'(dc_wdata_01), 256'(req01_q[0].wdata));
          if (dc_ok_01) void'(req01_q.pop_front());
        end
      end
      if (dc_valid_02) begin
        check("req02_expected", 256'(req02_q.size() != 0), 256'(1));
        if (req02_q.size() != 0) begin
          check("req02_addr", 256'(dc_addr_02), 256'(req02_q[0].addr));
          check("req02_op", 256'(dc_op_02), 256'(req02_q[0].op));
          check("req02_wstrb", 256'(dc_wstrb_02), 256'(req02_q[0].wstrb));
          if (req02_q[0].op) check("req02_wdata", 256'(dc_wdata_02), 256'(req02_q[0].wdata));
          if (dc_ok_02) void'(req02_q.pop_front());
        end
      end
      if (pms_to_ms_valid) begin
        check("handoff_expected", 256'(ms_q.size() != 0), 256'(1));
        if (ms_q.size() != 0) begin
          check("handoff_bus", 256'(pms_to_ms_bus), 256'(ms_q[0]));
          if (ms_allowin) void'(ms_q.pop_front());
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    es_to_pms_valid = 1'b0;
    es_to_pms_bus = '0;
    ms_allowin = 1'b1;
    dc_ok_01 = 1'b0;
    dc_ok_02 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ms_valid", 256'(pms_to_ms_valid), 256'(0));
    check("rst_dc_valid_01", 256'(dc_valid_01), 256'(0));
    check("rst_dc_valid_02", 256'(dc_valid_02), 256'(0));
    check("rst_allowin", 256'(pms_allowin), 256'(1));
    check("rst_fwd_valid", 256'(pms_forward_bus[78]), 256'(0));
    tick();
    reset = 1'b0;

    // Two ALU ops pass straight through
    ms_q.push_back({1'b1,
      mk_out(7'd0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0, 32'h0000_0200, 32'hBFC0_0004),
      mk_out(7'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0, 32'h0000_0100, 32'hBFC0_0000)});
    send({1'b1,
      mk_in(7'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0, 32'h0000_0200, 32'hBFC0_0004),
      mk_in(7'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h0, 32'h0000_0100, 32'hBFC0_0000)});
    @(negedge clk);
    check("alu_handoff", 256'(pms_to_ms_valid), 256'(1));
    check("alu_fwd", 256'(pms_forward_bus),
          256'({1'b1, 1'b0, 1'b1, 5'd3, 32'h0000_0100, 1'b0, 1'b1, 5'd4, 32'h0000_0200}));
    tick();

    // sw held for three cycles before addr_ok
    req01_q.push_back('{addr: 32'h0000_1004, op: 1'b1, wstrb: 4'b1111, wdata: 32'hAABB_CCDD});
    ms_q.push_back({1'b0, 113'd0,
      mk_out(7'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'hAABB_CCDD, 32'h0000_1004, 32'hBFC0_0010)});
    send({1'b0, 116'd0,
      mk_in(7'd0, 5'b00100, 1'b0, 1'b1, 1'b0, 5'd0, 32'hAABB_CCDD, 32'h0000_1004, 32'hBFC0_0010)});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("sw_wait_valid", 256'(dc_valid_01), 256'(1));
      check("sw_wait_no_handoff", 256'(pms_to_ms_valid), 256'(0));
    end
    tick();
    dc_ok_01 = 1'b1;
    @(negedge clk);
    check("sw_handoff_on_ok", 256'(pms_to_ms_valid), 256'(1));
    tick();
    dc_ok_01 = 1'b0;

    // sb + swr, port 02 accepted first
    req01_q.push_back('{addr: 32'h0000_2000, op: 1'b1, wstrb: 4'b1000, wdata: 32'h1212_1212});
    req02_q.push_back('{addr: 32'h0000_2000, op: 1'b1, wstrb: 4'b1100, wdata: 32'h3344_0000});
    ms_q.push_back({1'b1,
      mk_out(7'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1122_3344, 32'h0000_2002, 32'hBFC0_0024),
      mk_out(7'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0012, 32'h0000_2003, 32'hBFC0_0020)});
    send({1'b1,
      mk_in(7'd0, 5'b00001, 1'b0, 1'b1, 1'b0, 5'd0, 32'h1122_3344, 32'h0000_2002, 32'hBFC0_0024),
      mk_in(7'd0, 5'b10000, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0000_0012, 32'h0000_2003, 32'hBFC0_0020)});
    @(negedge clk);
    check("sbswr_no_handoff_0", 256'(pms_to_ms_valid), 256'(0));
    tick();
    dc_ok_02 = 1'b1;
    @(negedge clk);
    check("sbswr_no_handoff_1", 256'(pms_to_ms_valid), 256'(0));
    tick();
    dc_ok_02 = 1'b0;
    @(negedge clk);
    check("no_rerequest_02", 256'(dc_valid_02), 256'(0));
    check("sbswr_still_01", 256'(dc_valid_01), 256'(1));
    check("sbswr_no_handoff_2", 256'(pms_to_ms_valid), 256'(0));
    tick();
    dc_ok_01 = 1'b1;
    @(negedge clk);
    check("sbswr_handoff", 256'(pms_to_ms_valid), 256'(1));
    tick();
    dc_ok_01 = 1'b0;

    // lw accepted while mem_stage stalls for four cycles
    ms_allowin = 1'b0;
    req01_q.push_back('{addr: 32'h0000_3008, op: 1'b0, wstrb: 4'b0000, wdata: 32'h0});
    ms_q.push_back({1'b0, 113'd0,
      mk_out(7'b0000100, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0, 32'h0000_3008, 32'hBFC0_0030)});
    send({1'b0, 116'd0,
      mk_in(7'b0000100, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 32'h0, 32'h0000_3008, 32'hBFC0_0030)});
    dc_ok_01 = 1'b1;
    @(negedge clk);
    check("lw_req_pulse", 256'(dc_valid_01), 256'(1));
    tick();
    dc_ok_01 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("lw_stall_no_rereq", 256'(dc_valid_01), 256'(0));
      check("lw_stall_valid", 256'(pms_to_ms_valid), 256'(1));
      check("lw_stall_allowin", 256'(pms_allowin), 256'(0));
      tick();
    end
    ms_allowin = 1'b1;
    @(negedge clk);
    check("lw_release_allowin", 256'(pms_allowin), 256'(1));
    tick();

    // inst2 marked as store but inst2_valid=0
    ms_q.push_back({1'b0,
      mk_out(7'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h0000_4000, 32'hBFC0_0044),
      mk_out(7'd0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0, 32'h0000_0044, 32'hBFC0_0040)});
    send({1'b0,
      mk_in(7'd0, 5'b00100, 1'b0, 1'b1, 1'b0, 5'd0, 32'hDEAD_BEEF, 32'h0000_4000, 32'hBFC0_0044),
      mk_in(7'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7, 32'h0, 32'h0000_0044, 32'hBFC0_0040)});
    @(negedge clk);
    check("i2inv_no_req02", 256'(dc_valid_02), 256'(0));
    check("i2inv_handoff", 256'(pms_to_ms_valid), 256'(1));
    check("i2inv_fwd", 256'(pms_forward_bus),
          256'({1'b1, 1'b0, 1'b1, 5'd7, 32'h0000_0044, 39'd0}));
    tick();

    // sh + swl both accepted in the first request cycle
    req01_q.push_back('{addr: 32'h0000_5000, op: 1'b1, wstrb: 4'b1100, wdata: 32'h1234_1234});
    req02_q.push_back('{addr: 32'h0000_5000, op: 1'b1, wstrb: 4'b0011, wdata: 32'h0000_A1B2});
    ms_q.push_back({1'b1,
      mk_out(7'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'hA1B2_C3D4, 32'h0000_5001, 32'hBFC0_0054),
      mk_out(7'd0, 1'b0, 1'b1, 1'b0, 5'd0, 32'hCAFE_1234, 32'h0000_5002, 32'hBFC0_0050)});
    send({1'b1,
      mk_in(7'd0, 5'b00010, 1'b0, 1'b1, 1'b0, 5'd0, 32'hA1B2_C3D4, 32'h0000_5001, 32'hBFC0_0054),
      mk_in(7'd0, 5'b01000, 1'b0, 1'b1, 1'b0, 5'd0, 32'hCAFE_1234, 32'h0000_5002, 32'hBFC0_0050)});
    dc_ok_01 = 1'b1;
    dc_ok_02 = 1'b1;
    @(negedge clk);
    check("shswl_handoff", 256'(pms_to_ms_valid), 256'(1));
    tick();
    dc_ok_01 = 1'b0;
    dc_ok_02 = 1'b0;

    // Reset while a request is pending
    req01_q.push_back('{addr: 32'h0000_6000, op: 1'b1, wstrb: 4'b1111, wdata: 32'h5566_7788});
    send({1'b0, 116'd0,
      mk_in(7'd0, 5'b00100, 1'b0, 1'b1, 1'b0, 5'd0, 32'h5566_7788, 32'h0000_6000, 32'hBFC0_0060)});
    @(negedge clk);
    check("pre_rst_valid_01", 256'(dc_valid_01), 256'(1));
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_valid_01", 256'(dc_valid_01), 256'(0));
    check("async_rst_ms_valid", 256'(pms_to_ms_valid), 256'(0));
    req01_q.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("post_rst_allowin", 256'(pms_allowin), 256'(1));
      check("post_rst_valid_01", 256'(dc_valid_01), 256'(0));
      check("post_rst_ms_valid", 256'(pms_to_ms_valid), 256'(0));
    end

    check("req01_drained", 256'(req01_q.size()), 256'(0));
    check("req02_drained", 256'(req02_q.size()), 256'(0));
    check("handoff_drained", 256'(ms_q.size()), 256'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
